// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch queue entry and fetcher FSM states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // One buffered fetch: the PC it was fetched from and the returned word.
    typedef struct packed {
        word_t pc;
        word_t ins;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        FULL   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: icache request/response, redirect/halt control and
// decode-side valid/ready output. Optional FETCH_STATS_EN adds counter outputs.
interface fetch_queue_if
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             imemREN;
    word_t            imemaddr;
    logic             ihit;
    word_t            imemload;
    logic             redirect;
    word_t            redirect_pc;
    logic             halt;
    logic             out_valid;
    word_t            out_ins;
    word_t            out_pc;
    word_t            out_npc;
    logic             out_ready;
    logic [CNT_W-1:0] count;
`ifdef FETCH_STATS_EN
    word_t            fetch_cnt;
    word_t            stall_cnt;
`endif

    // Fetcher side.
    modport master (
        output imemREN, imemaddr, out_valid, out_ins, out_pc, out_npc, count,
`ifdef FETCH_STATS_EN
        output fetch_cnt, stall_cnt,
`endif
        input  ihit, imemload, redirect, redirect_pc, halt, out_ready
    );

    // Cache/decode/control side.
    modport slave (
        input  imemREN, imemaddr, out_valid, out_ins, out_pc, out_npc, count,
`ifdef FETCH_STATS_EN
        input  fetch_cnt, stall_cnt,
`endif
        output ihit, imemload, redirect, redirect_pc, halt, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with push, pop, flush, occupancy and head.
module fetch_fifo
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      push,
    input  fetch_entry_t              push_data,
    input  logic                      pop,
    input  logic                      flush,
    output logic [$clog2(DEPTH):0]    count,
    output fetch_entry_t              head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt_q;

    // Entry storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign count = cnt_q;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetcher: owns the fetch PC, requests from the icache
// and buffers returned words for decode. Optional macro FETCH_STATS_EN adds
// fetch_cnt / stall_cnt statistics outputs.
module fetch_queue
    import cpu_types_pkg::*;
#(
    parameter word_t       PC_INIT = '0,
    parameter int unsigned DEPTH   = 4
)
(
    input logic          CLK,
    input logic          RST,
    fetch_queue_if.master fq
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    word_t            fpc_q;
    word_t            fpc_d;
    logic             push;
    logic             pop;
    logic             valid;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     push_data;

    assign valid     = (count != '0);
    assign push_data = '{pc: fpc_q, ins: fq.imemload};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (fq.redirect),
        .count     (count),
        .head      (head)
    );

    // State and fetch PC registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FETCH;
            fpc_q   <= PC_INIT;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
        end
    end

    // Next state, fetch PC and queue push/pop; redirect discards ihit and pop.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        push    = 1'b0;
        pop     = 1'b0;

        pop  = valid && fq.out_ready && !fq.redirect;
        push = (state_q == FETCH) && fq.ihit && !fq.redirect;

        if (push) begin
            fpc_d = fpc_q + PC_STEP;
        end

        unique case (state_q)
            FETCH: begin
                if (push && !pop && (count == CNT_W'(DEPTH - 1))) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase

        if (fq.redirect) begin
            fpc_d   = fq.redirect_pc;
            state_d = FETCH;
        end

        if (fq.halt || (state_q == HALTED)) begin
            state_d = HALTED;
        end
    end

    // Request is a function of registered state; held low while in reset.
    assign fq.imemREN   = (state_q == FETCH) && !RST;
    assign fq.imemaddr  = fpc_q;
    assign fq.out_valid = valid;
    assign fq.out_ins   = head.ins;
    assign fq.out_pc    = head.pc;
    assign fq.out_npc   = head.pc + PC_STEP;
    assign fq.count     = count;

`ifdef FETCH_STATS_EN
    word_t fetch_cnt_q;
    word_t stall_cnt_q;

    // Pushed-instruction and FULL-cycle counters; survive redirects.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (state_q == FULL) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fq.fetch_cnt = fetch_cnt_q;
    assign fq.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end that replaces the single-cycle PC/instruction path with a decoupled fetcher. It owns the fetch PC, issues requests to the instruction cache, and buffers returned instructions with their PCs in a DEPTH-entry queue. The queue is drained by decode under a valid/ready handshake. It sits between the datapath_cache_if instruction port and the pipeline's decode stage, and supports redirect (branch/jump) flushes and halt.

## Interface
- PC_INIT, 0: fetch PC loaded on reset.
- DEPTH, 4: queue entries; power of two, ≥2.
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- imemREN  out  1  instruction read request to cache.
- imemaddr  out  32  request address (current fetch PC).
- ihit  in  1  cache returns imemload this cycle.
- imemload  in  32  instruction word.
- redirect  in  1  flush queue and restart at redirect_pc.
- redirect_pc  in  32  new fetch PC; must be word-aligned.
- halt  in  1  stop issuing new requests (sticky until reset).
- out_valid  out  1  queue head valid.
- out_ins  out  32  head instruction.
- out_pc  out  32  head PC.
- out_npc  out  32  out_pc + 4.
- out_ready  in  1  decode consumes head this cycle.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- States: FETCH, FULL, HALTED.
- FETCH: imemREN=1, imemaddr=fpc. On ihit: push {fpc, imemload}, fpc<=fpc+4. Go FULL if push makes count==DEPTH with no pop.
- FULL: imemREN=0. Leave to FETCH when a pop occurs (count<DEPTH next cycle).
- HALTED: imemREN=0 permanently; queue still drains. Entered from any state when halt=1; only RST exits.
- Pop: out_valid & out_ready. Push and pop in same cycle: count unchanged.
- Redirect (highest priority except reset): queue emptied (count<=0, out_valid 0 next cycle), fpc<=redirect_pc, any ihit that cycle discarded, pop ignored, state<=FETCH unless halted. Redirect with halt: flush still applies, state HALTED.
- PC arithmetic: 32-bit, +4 wraps 0xFFFFFFFC→0x00000000.
- Read/write pointers $clog2(DEPTH) bits, wrap naturally.

## Timing
- Reset values: fpc=PC_INIT, count=0, out_valid=0, out_ins=0, out_pc=0, out_npc=4 (0 pc +4), imemREN=0 while RST high, state FETCH.
- First cycle after RST falls: imemREN=1, imemaddr=PC_INIT.
- Latency: instruction captured on ihit edge is at head one cycle later if queue was empty.
- imemREN/imemaddr are registered-state functions only; no combinational path from out_ready or ihit to imemREN.
- out_* driven from queue storage; no ihit-to-out bypass.
- Redirect takes effect at the clock edge; imemaddr=redirect_pc the following cycle.
- RST mid-operation: all state cleared asynchronously; in-flight ihit ignored.

## Configuration
- FETCH_STATS_EN defined: adds outputs fetch_cnt (32, instructions pushed) and stall_cnt (32, cycles in FULL), both reset to 0, wrap on overflow, not cleared by redirect.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Add fetch_entry_t (packed struct: word_t pc, word_t ins) and fetch_state_t enum (FETCH, FULL, HALTED) to cpu_types_pkg; use word_t throughout.
- Sub-module fetch_fifo (#(DEPTH)): circular buffer of fetch_entry_t with push, pop, flush, count, head; fetch_queue holds fpc and FSM.

## Test plan
- Reset, PC_INIT=0x100, ihit every cycle, out_ready=0 → imemaddr 0x100,0x104,0x108,0x10C pushed; count=4, imemREN=0 in FULL.
- From full, out_ready=1 one cycle → head 0x100 popped, count=3, imemREN=1 next cycle at imemaddr 0x110.
- ihit and out_ready both every cycle, steady state → count constant, out_pc increments by 4 each cycle, no gaps.
- redirect=1, redirect_pc=0x400 with ihit same cycle and count=3 → count 0, discarded word not enqueued, next imemaddr 0x400.
- halt=1 with count=2 → imemREN 0 forever; two pops drain queue; out_valid 0 after.
- fpc=0xFFFFFFFC, ihit → entry pc 0xFFFFFFFC, out_npc 0x00000000, next imemaddr 0x0; with FETCH_STATS_EN, fetch_cnt increments per push, stall_cnt per FULL cycle.
